// File: rtl/battle_datapath.sv
// Battle datapath: HP registers, heal budget, damage calculation, catch verdict
// and a free-running 8-bit LFSR that feeds damage variance and catch odds.
module battle_datapath #(
    parameter int unsigned HP_W       = 8,
    parameter int unsigned P_MAX_HP   = 100,
    parameter int unsigned AI_MAX_HP  = 120,
    parameter int unsigned P_ATK      = 20,
    parameter int unsigned AI_ATK     = 15,
    parameter int unsigned P_DEF      = 10,
    parameter int unsigned AI_DEF     = 8,
    parameter int unsigned HEAL_AMT   = 30,
    parameter int unsigned MAX_HEALS  = 3,
    parameter int unsigned VAR_EN     = 1,
    parameter int unsigned CATCH_BASE = 16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            active_trainer,
    input  logic            target,
    input  logic            apply_ai_damage,
    input  logic            apply_p_damage,
    input  logic            p_heal,
    input  logic            catch,
    input  logic            load_ai_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic [HP_W-1:0] p_hp,
    output logic            ai_dead,
    output logic            p_dead,
    output logic            catch_success,
    output logic [1:0]      heals_left,
    output logic            heal_denied,
    output logic [HP_W-1:0] last_dmg
);

    localparam int unsigned DW = HP_W + 1;

    localparam logic [HP_W:0]   P_ATK_W   = DW'(P_ATK);
    localparam logic [HP_W:0]   AI_ATK_W  = DW'(AI_ATK);
    localparam logic [HP_W:0]   P_DEF_W   = DW'(P_DEF);
    localparam logic [HP_W:0]   AI_DEF_W  = DW'(AI_DEF);
    localparam logic [HP_W:0]   HEAL_W    = DW'(HEAL_AMT);
    localparam logic [HP_W:0]   P_MAX_W   = DW'(P_MAX_HP);
    localparam logic [HP_W-1:0] P_MAX_N   = HP_W'(P_MAX_HP);
    localparam logic [HP_W-1:0] AI_MAX_N  = HP_W'(AI_MAX_HP);
    localparam logic [HP_W-1:0] CATCH_HP  = HP_W'(AI_MAX_HP / 4);
    localparam logic [8:0]      CATCH_LIM = 9'(CATCH_BASE);

    logic [HP_W-1:0] ai_hp_q, ai_hp_d;
    logic [HP_W-1:0] p_hp_q, p_hp_d;
    logic            ai_dead_q, ai_dead_d;
    logic            p_dead_q, p_dead_d;
    logic [1:0]      heals_left_q, heals_left_d;
    logic            heal_denied_q, heal_denied_d;
    logic [HP_W-1:0] last_dmg_q, last_dmg_d;
    logic [7:0]      lfsr_q, lfsr_d;

    logic [HP_W:0]   atk, half_def, var_add, gross, dmg;
    logic [HP_W:0]   healed_sum;
    logic [HP_W-1:0] p_after_heal;
    logic            frozen;
    logic            heal_ok;

    // Saturating subtract; the operand is one bit wider so a large damage never wraps.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                 input logic [HP_W:0]   b);
        return ({1'b0, a} > b) ? (a - b[HP_W-1:0]) : '0;
    endfunction

    // Damage for the current attacker/defender pair, never below 1.
    always_comb begin
        atk      = active_trainer ? AI_ATK_W : P_ATK_W;
        half_def = (target ? AI_DEF_W : P_DEF_W) >> 1;
        var_add  = (VAR_EN != 0) ? {{(HP_W - 1){1'b0}}, lfsr_q[1:0]} : '0;
        gross    = atk + var_add;
        dmg      = (gross > half_def) ? (gross - half_def) : DW'(1);
    end

    // Next-state for HP, death flags, heal budget and LFSR.
    always_comb begin
        frozen        = ai_dead_q | p_dead_q;
        heal_ok       = p_heal & (heals_left_q != 2'd0);
        healed_sum    = {1'b0, p_hp_q} + HEAL_W;
        p_after_heal  = heal_ok ? ((healed_sum > P_MAX_W) ? P_MAX_N : healed_sum[HP_W-1:0])
                                : p_hp_q;

        ai_hp_d       = ai_hp_q;
        p_hp_d        = p_hp_q;
        ai_dead_d     = ai_dead_q;
        p_dead_d      = p_dead_q;
        heals_left_d  = heals_left_q;
        heal_denied_d = 1'b0;
        last_dmg_d    = last_dmg_q;
        // Taps 8,6,5,4 (bits 7,5,4,3); maximal length so a nonzero seed never reaches 0.
        lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (!frozen) begin
            // Player side: heal lands before any damage in the same cycle.
            if (p_heal) begin
                if (heal_ok) begin
                    heals_left_d = heals_left_q - 2'd1;
                end else begin
                    heal_denied_d = 1'b1;
                end
            end
            p_hp_d = p_after_heal;
            if (apply_p_damage && !target) begin
                p_hp_d     = sat_sub(p_after_heal, dmg);
                last_dmg_d = dmg[HP_W-1:0];
                if (p_hp_d == '0) begin
                    p_dead_d = 1'b1;
                end
            end
            // AI side written last so its damage wins last_dmg.
            if (apply_ai_damage && target && !load_ai_hp) begin
                ai_hp_d    = sat_sub(ai_hp_q, dmg);
                last_dmg_d = dmg[HP_W-1:0];
                if (ai_hp_d == '0) begin
                    ai_dead_d = 1'b1;
                end
            end
        end

        // Reload revives the AI even in a frozen battle.
        if (load_ai_hp) begin
            ai_hp_d   = AI_MAX_N;
            ai_dead_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ai_hp_q       <= AI_MAX_N;
            p_hp_q        <= P_MAX_N;
            ai_dead_q     <= 1'b0;
            p_dead_q      <= 1'b0;
            heals_left_q  <= 2'(MAX_HEALS);
            heal_denied_q <= 1'b0;
            last_dmg_q    <= '0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            ai_hp_q       <= ai_hp_d;
            p_hp_q        <= p_hp_d;
            ai_dead_q     <= ai_dead_d;
            p_dead_q      <= p_dead_d;
            heals_left_q  <= heals_left_d;
            heal_denied_q <= heal_denied_d;
            last_dmg_q    <= last_dmg_d;
            lfsr_q        <= lfsr_d;
        end
    end

    // Catch verdict is combinational so the FSM can branch in the same cycle.
    always_comb begin
        catch_success = catch & ~ai_dead_q & ~p_dead_q &
                        ((ai_hp_q <= CATCH_HP) | ({1'b0, lfsr_q} < CATCH_LIM));
    end

    assign ai_hp       = ai_hp_q;
    assign p_hp        = p_hp_q;
    assign ai_dead     = ai_dead_q;
    assign p_dead      = p_dead_q;
    assign heals_left  = heals_left_q;
    assign heal_denied = heal_denied_q;
    assign last_dmg    = last_dmg_q;

endmodule

// File: tb/tb_battle_datapath.sv
// Directed bench: deterministic instance (no variance, no random catch) plus a
// default-parameter instance checked against an LFSR reference.
module tb_battle_datapath;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic active_trainer, target, apply_ai_damage, apply_p_damage, p_heal, catch, load_ai_hp;
    logic [7:0] ai_hp, p_hp, last_dmg;
    logic ai_dead, p_dead, catch_success, heal_denied;
    logic [1:0] heals_left;

    logic v_active, v_target, v_apply_ai, v_catch;
    logic [7:0] v_ai_hp, v_p_hp, v_last_dmg;
    logic v_ai_dead, v_p_dead, v_catch_success, v_heal_denied;
    logic [1:0] v_heals_left;

    logic [7:0] m_lfsr;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    battle_datapath #(.VAR_EN(0), .CATCH_BASE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .active_trainer(active_trainer), .target(target),
        .apply_ai_damage(apply_ai_damage), .apply_p_damage(apply_p_damage), .p_heal(p_heal),
        .catch(catch), .load_ai_hp(load_ai_hp), .ai_hp(ai_hp), .p_hp(p_hp),
        .ai_dead(ai_dead), .p_dead(p_dead), .catch_success(catch_success),
        .heals_left(heals_left), .heal_denied(heal_denied), .last_dmg(last_dmg)
    );

    battle_datapath u_var (
        .clk(clk), .reset_n(reset_n), .active_trainer(v_active), .target(v_target),
        .apply_ai_damage(v_apply_ai), .apply_p_damage(1'b0), .p_heal(1'b0),
        .catch(v_catch), .load_ai_hp(1'b0), .ai_hp(v_ai_hp), .p_hp(v_p_hp),
        .ai_dead(v_ai_dead), .p_dead(v_p_dead), .catch_success(v_catch_success),
        .heals_left(v_heals_left), .heal_denied(v_heal_denied), .last_dmg(v_last_dmg)
    );

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        active_trainer = 0; target = 0; apply_ai_damage = 0; apply_p_damage = 0;
        p_heal = 0; catch = 0; load_ai_hp = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_p_hp"}, p_hp, 100);
        chk({tag, "_ai_hp"}, ai_hp, 120);
        chk({tag, "_heals"}, heals_left, 3);
        chk({tag, "_ai_dead"}, ai_dead, 0);
        chk({tag, "_p_dead"}, p_dead, 0);
        chk({tag, "_last_dmg"}, last_dmg, 0);
        chk({tag, "_denied"}, heal_denied, 0);
    endtask

    initial begin
        logic [7:0] exp_hp;
        logic [7:0] exp_d;
        clr();
        v_active = 0; v_target = 0; v_apply_ai = 0; v_catch = 0;

        // Power-on reset
        repeat (2) step();
        chk_reset("por");
        chk("por_v_ai_hp", v_ai_hp, 120);
        reset_n = 1;

        // Player hits AI: 20 - 8/2 = 16
        apply_ai_damage = 1; target = 1;
        step(); chk("hit1", ai_hp, 104);
        step(); chk("hit2", ai_hp, 88);
        step(); chk("hit3", ai_hp, 72); chk("hit3_dmg", last_dmg, 16);
        // Wrong target ignored
        target = 0;
        step(); chk("wrong_tgt", ai_hp, 72);
        target = 1;
        step(); chk("hit4", ai_hp, 56);
        step(); chk("hit5", ai_hp, 40);
        // Catch above quarter HP with CATCH_BASE=0 fails
        apply_ai_damage = 0; catch = 1;
        #1 chk("catch_40", catch_success, 0);
        catch = 0; apply_ai_damage = 1;
        step(); chk("hit6", ai_hp, 24);
        apply_ai_damage = 0; catch = 1;
        #1 chk("catch_24", catch_success, 1);
        catch = 0;
        #1 chk("catch_off", catch_success, 0);
        apply_ai_damage = 1;
        step(); chk("hit7", ai_hp, 8); chk("alive_8", ai_dead, 0);
        step(); chk("hit8", ai_hp, 0); chk("ai_dead", ai_dead, 1);
        apply_ai_damage = 0; catch = 1;
        #1 chk("catch_dead", catch_success, 0);
        catch = 0;

        // Frozen: AI attack on player ignored
        apply_p_damage = 1; active_trainer = 1; target = 0;
        step(); chk("frozen_p", p_hp, 100);
        clr();

        // Reload overrides same-cycle damage
        load_ai_hp = 1; apply_ai_damage = 1; target = 1;
        step(); chk("reload_hp", ai_hp, 120); chk("reload_dead", ai_dead, 0);
        clr();
        // AI hits itself: 15 - 8/2 = 11
        apply_ai_damage = 1; target = 1; active_trainer = 1;
        step(); chk("ai_self", ai_hp, 109); chk("ai_self_dmg", last_dmg, 11);
        clr();

        // AI hits player: 15 - 10/2 = 10
        apply_p_damage = 1; active_trainer = 1; target = 0;
        step(); chk("p_hit1", p_hp, 90);
        step(); chk("p_hit2", p_hp, 80);
        step(); chk("p_hit3", p_hp, 70); chk("p_hit3_dmg", last_dmg, 10);
        clr();
        p_heal = 1;
        step(); chk("heal1", p_hp, 100); chk("heal1_left", heals_left, 2);
        step(); chk("heal2", p_hp, 100); chk("heal2_left", heals_left, 1);
        step(); chk("heal3_left", heals_left, 0); chk("heal3_den", heal_denied, 0);
        step(); chk("heal4", p_hp, 100); chk("heal4_den", heal_denied, 1);
        chk("heal4_left", heals_left, 0);
        p_heal = 0;
        step(); chk("den_pulse", heal_denied, 0);

        // Asynchronous mid-cycle reset
        #2 reset_n = 0;
        #1 chk_reset("mid");
        #2 reset_n = 1;

        // Bring player to 50, then heal + damage together
        apply_p_damage = 1; active_trainer = 1; target = 0;
        repeat (5) step();
        chk("p_50", p_hp, 50);
        p_heal = 1;
        step(); chk("heal_dmg", p_hp, 70); chk("heal_dmg_left", heals_left, 2);
        p_heal = 0;
        // Player hits itself: 20 - 10/2 = 15
        active_trainer = 0;
        repeat (3) step();
        chk("self_25", p_hp, 25); chk("self_dmg", last_dmg, 15);
        active_trainer = 1;
        repeat (2) step();
        chk("p_5", p_hp, 5); chk("p_alive", p_dead, 0);
        step(); chk("p_zero", p_hp, 0); chk("p_dead", p_dead, 1);
        clr();
        p_heal = 1;
        step(); chk("dead_heal", p_hp, 0); chk("dead_heal_left", heals_left, 2);
        chk("dead_heal_den", heal_denied, 0);
        clr();
        apply_ai_damage = 1; target = 1;
        step(); chk("frozen_ai", ai_hp, 120);
        clr();

        // Variance instance: catch odds follow the LFSR at full HP
        v_catch = 1;
        step();
        for (int i = 0; i < 40; i++) begin
            chk("v_catch", v_catch_success, (m_lfsr < 8'd16) ? 1 : 0);
            step();
        end
        v_catch = 0;
        // Damage = 20 + lfsr[1:0] - 4
        exp_hp = 8'd120;
        v_apply_ai = 1; v_target = 1;
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'd16 + {6'd0, m_lfsr[1:0]};
            exp_hp = exp_hp - exp_d;
            step();
            chk("v_hp", v_ai_hp, exp_hp);
            chk("v_dmg", v_last_dmg, exp_d);
        end
        v_apply_ai = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/battle_datapath.md
Name: battle_datapath

Overview:
- Downstream datapath for the battle control FSM; consumes its one-hot enables (apply_ai_damage, apply_p_damage, p_heal, catch, load_ai_hp) and qualifiers (active_trainer, target).
- Holds both Pokemon HP registers, heal budget and an LFSR.
- Returns ai_dead, p_dead and catch_success to the FSM.
- Drives HP and last-damage values for display.

Parameters:
HP_W, 8, HP/damage width
P_MAX_HP, 100, player full HP
AI_MAX_HP, 120, AI full HP
P_ATK, 20, player attack
AI_ATK, 15, AI attack
P_DEF, 10, player defence
AI_DEF, 8, AI defence
HEAL_AMT, 30, HP restored per heal
MAX_HEALS, 3, heals per battle (<=3)
VAR_EN, 1, 1 adds lfsr[1:0] damage variance
CATCH_BASE, 16, catch succeeds if lfsr < CATCH_BASE
LFSR_SEED, 8'hA5, nonzero LFSR reset value

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
active_trainer  in  1  attacker: 0 player, 1 AI
target  in  1  defender: 0 player, 1 AI
apply_ai_damage  in  1  damage AI this cycle
apply_p_damage  in  1  damage player this cycle
p_heal  in  1  heal player this cycle
catch  in  1  catch attempt this cycle
load_ai_hp  in  1  reload AI to AI_MAX_HP
ai_hp  out  HP_W  AI HP
p_hp  out  HP_W  player HP
ai_dead  out  1  AI HP reached 0 (sticky)
p_dead  out  1  player HP reached 0 (sticky)
catch_success  out  1  combinational catch verdict
heals_left  out  2  remaining heals
heal_denied  out  1  one-cycle pulse: heal requested with none left
last_dmg  out  HP_W  most recent damage applied

Behaviour:
- Reset: reset_n low asynchronously sets p_hp=P_MAX_HP, ai_hp=AI_MAX_HP, ai_dead=p_dead=0, heals_left=MAX_HEALS, heal_denied=0, last_dmg=0, lfsr=LFSR_SEED. Mid-battle reset takes effect immediately, without waiting for clk.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clk; never 0.
- Enable semantics: each enable is level-sampled. Every cycle it is high applies one update at that posedge, so consecutive high cycles apply repeatedly. All updates take 1-cycle latency.
- Damage formula, evaluated in HP_W+1 bits:
  - atk = active_trainer ? AI_ATK : P_ATK
  - def = target ? AI_DEF : P_DEF
  - raw = atk + (VAR_EN ? lfsr[1:0] : 0) - def/2 (integer shift)
  - dmg = max(raw, 1)
- apply_ai_damage: acts only if target=1, otherwise ignored. ai_hp <= saturating ai_hp - dmg (floor 0). last_dmg <= dmg.
- apply_p_damage: acts only if target=0, otherwise ignored. Same saturating subtract on p_hp; last_dmg <= dmg.
- Player heal:
  - p_heal with heals_left>0: p_hp <= min(p_hp + HEAL_AMT, P_MAX_HP); heals_left decrements.
  - p_heal with heals_left=0: p_hp unchanged; heal_denied=1 for that cycle (registered pulse, next cycle).
- Simultaneous p_heal and apply_p_damage: heal first, then damage. Result = sat(min(p_hp+HEAL_AMT, max) - dmg).
- Simultaneous damage to both sides: both applied; last_dmg takes the AI-side value.
- Death flags:
  - ai_dead/p_dead set on the edge where the corresponding next HP is 0; visible the cycle after the killing hit.
  - Once either flag is 1, all damage, heal and catch effects are ignored (battle frozen). The LFSR keeps running.
  - Both reaching 0 on the same edge: both flags set. FSM priority resolves to victory.
- load_ai_hp: ai_hp <= AI_MAX_HP, ai_dead <= 0. Overrides apply_ai_damage on the same cycle. Not blocked by the freeze.
- catch_success: combinational = catch & ~ai_dead & ~p_dead & ((ai_hp <= AI_MAX_HP/4) | (lfsr < CATCH_BASE)). Valid in the same cycle catch is high so the FSM can branch on it. 0 whenever catch=0. Catch changes no state in this block.
- No other state; outputs all registered except catch_success.

Test Plan:
- Reset, then hold reset_n low mid-cycle -> immediately p_hp=100, ai_hp=120, heals_left=3, dead flags 0, last_dmg=0.
- VAR_EN=0; 3 cycles of apply_ai_damage, target=1, active_trainer=0 -> ai_hp 104, 88, 72; last_dmg=16. Repeat with target=0 -> ai_hp unchanged.
- VAR_EN=0; 8 AI hits (ai_hp 8 -> 0) -> ai_dead=1 next cycle. A following apply_p_damage (active_trainer=1, target=0) leaves p_hp=100. load_ai_hp -> ai_hp=120, ai_dead=0.
- Heal budget -> required responses:
  - 3 player hits -> p_hp=70 (dmg 10).
  - p_heal -> 100 (capped).
  - Two further heals -> heals_left=0.
  - 4th p_heal -> p_hp unchanged, heal_denied pulses once.
- Simultaneous p_heal + apply_p_damage at p_hp=50, heals_left>0 -> p_hp=70. p_hp=5, damage only -> p_hp=0, p_dead=1.
- Catch -> required responses:
  - ai_hp=24, catch=1 -> catch_success=1 same cycle.
  - ai_hp=120, CATCH_BASE=0 -> catch_success=0.
  - catch=0 -> catch_success=0 always.
